sand_updater: RTL

Physics engine for the falling-sand grid. On a `start_i` pulse it makes one full pass over the cell grid held in `register_file`. It drives that memory's read port and its write port, and moves each sand grain down, down-left or down-right into an empty cell. It is the read/modify/write client that sits opposite the register file; the frame tick in the top level triggers it once per frame.

---
 rtl/sand_updater.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/sand_updater.sv
// Falling-sand physics pass: scans the grid bottom-up through a synchronous-read
// memory and moves each grain down, down-left or down-right into an empty cell.
module sand_updater #(
    parameter int GRID_W     = 16,
    parameter int GRID_H     = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] read_address_o,
    input  logic [DATA_WIDTH-1:0] read_data_i,
    output logic                  write_en_o,
    output logic [ADDR_WIDTH-1:0] write_address_o,
    output logic [DATA_WIDTH-1:0] write_data_o,
    output logic [3:0]            debug_state_o
);

    localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int YW = $clog2(GRID_H);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        RD_C = 4'd1,
        EV_C = 4'd2,
        RD_B = 4'd3,
        EV_B = 4'd4,
        RD_L = 4'd5,
        EV_L = 4'd6,
        RD_R = 4'd7,
        EV_R = 4'd8,
        WR_D = 4'd9,
        WR_S = 4'd10,
        DONE = 4'd11
    } state_t;

    state_t                state_q, state_d;
    logic [XW-1:0]         x_q;
    logic [YW-1:0]         y_q;
    logic [DATA_WIDTH-1:0] grain_q;
    logic [ADDR_WIDTH-1:0] target_q, target_d;

    logic                  advance;
    logic                  latch_grain;
    logic                  load_target;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] below_addr;
    logic [ADDR_WIDTH-1:0] left_addr;
    logic [ADDR_WIDTH-1:0] right_addr;
    logic                  has_left;
    logic                  has_right;
    logic                  last_cell;
    logic                  cell_empty;

    function automatic logic [ADDR_WIDTH-1:0] cell_addr(input int x, input int y);
        return ADDR_WIDTH'(y * GRID_W + x);
    endfunction

    // Neighbour addresses; left/right are only ever presented when in-grid.
    always_comb begin
        cur_addr   = cell_addr(int'(x_q), int'(y_q));
        below_addr = cell_addr(int'(x_q), int'(y_q) + 1);
        left_addr  = cell_addr(int'(x_q) - 1, int'(y_q) + 1);
        right_addr = cell_addr(int'(x_q) + 1, int'(y_q) + 1);
        has_left   = (x_q != '0);
        has_right  = (int'(x_q) < GRID_W - 1);
        last_cell  = (int'(x_q) == GRID_W - 1) && (y_q == '0);
        cell_empty = (read_data_i == '0);
    end

    always_comb begin
        state_d         = state_q;
        busy_o          = 1'b0;
        done_o          = 1'b0;
        read_address_o  = '0;
        write_en_o      = 1'b0;
        write_address_o = '0;
        write_data_o    = '0;
        advance         = 1'b0;
        latch_grain     = 1'b0;
        load_target     = 1'b0;
        target_d        = below_addr;

        case (state_q)
            IDLE: begin
                if (start_i) state_d = RD_C;
            end
            RD_C: begin
                busy_o         = 1'b1;
                read_address_o = cur_addr;
                state_d        = EV_C;
            end
            EV_C: begin
                busy_o = 1'b1;
                if (cell_empty) begin
                    advance = 1'b1;
                end else begin
                    latch_grain = 1'b1;
                    state_d     = RD_B;
                end
            end
            RD_B: begin
                busy_o         = 1'b1;
                read_address_o = below_addr;
                state_d        = EV_B;
            end
            EV_B: begin
                busy_o = 1'b1;
                if (cell_empty) begin
                    load_target = 1'b1;
                    target_d    = below_addr;
                    state_d     = WR_D;
                end else if (has_left) begin
                    state_d = RD_L;
                end else if (has_right) begin
                    state_d = RD_R;
                end else begin
                    advance = 1'b1;
                end
            end
            RD_L: begin
                busy_o         = 1'b1;
                read_address_o = left_addr;
                state_d        = EV_L;
            end
            EV_L: begin
                busy_o = 1'b1;
                if (cell_empty) begin
                    load_target = 1'b1;
                    target_d    = left_addr;
                    state_d     = WR_D;
                end else if (has_right) begin
                    state_d = RD_R;
                end else begin
                    advance = 1'b1;
                end
            end
            RD_R: begin
                busy_o         = 1'b1;
                read_address_o = right_addr;
                state_d        = EV_R;
            end
            EV_R: begin
                busy_o = 1'b1;
                if (cell_empty) begin
                    load_target = 1'b1;
                    target_d    = right_addr;
                    state_d     = WR_D;
                end else begin
                    advance = 1'b1;
                end
            end
            // Destination is written before the source is cleared, so an
            // interrupted move never loses the grain.
            WR_D: begin
                busy_o          = 1'b1;
                write_en_o      = 1'b1;
                write_address_o = target_q;
                write_data_o    = grain_q;
                state_d         = WR_S;
            end
            WR_S: begin
                busy_o          = 1'b1;
                write_en_o      = 1'b1;
                write_address_o = cur_addr;
                write_data_o    = '0;
                advance         = 1'b1;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (advance) state_d = last_cell ? DONE : RD_C;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            grain_q  <= '0;
            target_q <= '0;
        end else begin
            state_q <= state_d;
            // The floor row is never a source, so the scan begins one row above it.
            if (state_q == IDLE && start_i) begin
                x_q <= '0;
                y_q <= YW'(GRID_H - 2);
            end else if (advance) begin
                if (int'(x_q) == GRID_W - 1) begin
                    x_q <= '0;
                    y_q <= y_q - 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end
            if (latch_grain) grain_q <= read_data_i;
            if (load_target) target_q <= target_d;
        end
    end

    assign debug_state_o = state_q;

endmodule
